data_mem_ctrl: RTL

Data-memory controller sitting directly downstream of the `riscv_small` memory-access stage. It accepts byte/half/word load and store requests, checks alignment and range, and drives byte-lane enables into a word-wide synchronous SRAM. It returns sign- or zero-extended load data with a single-cycle `data_ready` pulse after a programmable number of wait states.

---
 rtl/riscv_definitions.sv | 37 +++
 rtl/dmem_sram.sv | 28 ++
 rtl/data_mem_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_definitions.sv
// rtl/riscv_definitions.sv - shared types and lane helpers for the data-memory path
package riscv_definitions;

    typedef logic [31:0] dataBus_u;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] offset);
        case (size)
            MEM_BYTE: return 4'b0001 << offset;
            MEM_HALF: return 4'b0011 << {offset[1], 1'b0};
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic dataBus_u extract(input dataBus_u word, input mem_size_e size,
                                         input logic [1:0] offset, input logic is_unsigned);
        dataBus_u shifted;
        shifted = word >> {offset, 3'b000};
        case (size)
            MEM_BYTE: return is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            MEM_HALF: return is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default:  return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - word-wide synchronous SRAM with byte write enables, read-before-write
module dmem_sram
    import riscv_definitions::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  dataBus_u                       wdata,
    output dataBus_u                       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store controller: request latch, error check, wait states, lane steering
module data_mem_ctrl
    import riscv_definitions::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        data_rd_en_ma,
    input  logic        data_wr_en_ma,
    input  logic [31:0] data_addr,
    input  dataBus_u    data_wr,
    input  logic [1:0]  data_rd_wr_ctrl,
    input  logic        data_unsigned,
    output logic        data_ready,
    output dataBus_u    data_rd,
    output logic        data_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_e   state_q, state_d;
    logic [3:0]    cnt_q;
    logic [AW+1:0] addr_q;
    mem_size_e     size_q;
    dataBus_u      wdata_q;
    logic          write_q, uns_q, err_q;

    logic          req, err_in, last_cycle;
    logic [AW+1:0] cur_addr;
    mem_size_e     cur_size;
    dataBus_u      cur_wdata, sram_wdata, sram_rdata;
    logic          cur_write, cur_err, sram_en;
    logic [3:0]    sram_we;

    assign req = data_rd_en_ma || data_wr_en_ma;

    assign err_in = (data_rd_en_ma && data_wr_en_ma)
                 || (data_rd_wr_ctrl == 2'b11)
                 || (data_rd_wr_ctrl == MEM_HALF && data_addr[0])
                 || (data_rd_wr_ctrl == MEM_WORD && data_addr[1:0] != 2'b00)
                 || ({2'b00, data_addr[31:2]} >= 32'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_ready = (state_q == RESP);
        data_err   = (state_q == RESP) && err_q;
        data_rd    = '0;
        if (state_q == RESP && !err_q && !write_q) begin
            data_rd = extract(sram_rdata, size_q, addr_q[1:0], uns_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= MEM_BYTE;
            wdata_q <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (clk_en) begin
            if (state_q == IDLE && req) begin
                cnt_q   <= WAIT_LOAD;
                addr_q  <= data_addr[AW+1:0];
                size_q  <= mem_size_e'(data_rd_wr_ctrl);
                wdata_q <= data_wr;
                write_q <= data_wr_en_ma;
                uns_q   <= data_unsigned;
                err_q   <= err_in;
            end else if (state_q == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // With no wait states the strobe fires in the sampling cycle, so the SRAM sees live inputs.
    always_comb begin
        if (state_q == IDLE) begin
            cur_addr  = data_addr[AW+1:0];
            cur_size  = mem_size_e'(data_rd_wr_ctrl);
            cur_wdata = data_wr;
            cur_write = data_wr_en_ma;
            cur_err   = err_in;
        end else begin
            cur_addr  = addr_q;
            cur_size  = size_q;
            cur_wdata = wdata_q;
            cur_write = write_q;
            cur_err   = err_q;
        end
    end

    assign last_cycle = (state_q == IDLE && req && WAIT_STATES == 0)
                     || (state_q == WAIT && cnt_q == 4'd0);
    // rst_n gates the strobe so a store caught by reset in its final wait cycle never commits.
    assign sram_en    = rst_n && clk_en && last_cycle && !cur_err;
    assign sram_we    = cur_write ? lane_mask(cur_size, cur_addr[1:0]) : 4'b0000;

    always_comb begin
        case (cur_size)
            MEM_BYTE: sram_wdata = {4{cur_wdata[7:0]}};
            MEM_HALF: sram_wdata = {2{cur_wdata[15:0]}};
            default:  sram_wdata = cur_wdata;
        endcase
    end

    dmem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (cur_addr[AW+1:2]),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

endmodule
